// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte/half/word data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    // Per-request sideband carried alongside the read data.
    typedef struct packed {
        logic       vld;
        logic       we;
        logic       err;
        logic       uns;
        size_e      size;
        logic [1:0] off;
    } sb_t;

    // Select the addressed lane(s) from a RAM word and sign/zero extend.
    function automatic logic [31:0] ld_extend(input logic [31:0] data, input logic [1:0] off,
                                              input size_e size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(data >> {off, 3'b000});
        h = off[1] ? data[31:16] : data[15:0];
        case (size)
            SZ_B:    r = {{24{~uns & b[7]}}, b};
            SZ_H:    r = {{16{~uns & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    // Byte-lane write enables for a store.
    function automatic logic [3:0] st_mask(input logic [1:0] off, input size_e size);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data so every candidate lane sees it.
    function automatic logic [31:0] st_align(input logic [31:0] wdata, input logic [1:0] off,
                                             input size_e size);
        logic [31:0] r;
        case (size)
            SZ_B:    r = {4{wdata[7:0]}};
            SZ_H:    r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        // Lane choice is made entirely by st_mask; offset is irrelevant here.
        if (off == 2'b00) r = r;
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// DEPTH x 32-bit RAM with four byte-lane write enables and a registered 1-cycle read.
module dmem_lane_ram #(
    parameter int unsigned ADDR_W    = 14,
    parameter string       INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Lane writes and read-first registered read; no reset so the array maps to BRAM.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lane_pipe.sv
// Data memory with byte/half/word access, load extension and a READ_LAT-deep response pipe.
// Define DMEM_STATS_EN to add saturating load/store/error counters.
module dmem_lane_pipe #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned READ_LAT  = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    , output logic [31:0] stat_rd_cnt
    , output logic [31:0] stat_wr_cnt
    , output logic [31:0] stat_err_cnt
`endif
);
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic        ready_q, ready_d;
    logic        accept, err;
    size_e       size;
    logic [1:0]  off;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, ram_rdata, ld_data;
    sb_t         sb_d [READ_LAT];
    sb_t         sb_q [READ_LAT];
    sb_t         sb_out;

    // Request decode, error check and store lane generation.
    always_comb begin
        size      = size_e'(req_size);
        off       = req_addr[1:0];
        accept    = req_valid & ready_q;
        ready_d   = 1'b1;
        err       = (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00) ||
                    (size == SZ_RSV) || ({2'b00, req_addr[31:2]} >= DEPTH);
        ram_we    = (accept && req_we && !err) ? st_mask(off, size) : 4'b0000;
        ram_wdata = st_align(req_wdata, off, size);
    end

    dmem_lane_ram #(
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clock(clock),
        .en   (accept),
        .we   (ram_we),
        .addr (req_addr[ADDR_W+1:2]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Sideband shift: stage 0 captures the accepted request.
    always_comb begin
        sb_d[0] = '{vld: accept, we: req_we, err: err, uns: req_unsigned, size: size, off: off};
        for (int i = 1; i < READ_LAT; i++) sb_d[i] = sb_q[i-1];
    end

    // Ready and sideband registers; reset drops everything in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) sb_q[i] <= '0;
        end else begin
            ready_q <= ready_d;
            for (int i = 0; i < READ_LAT; i++) sb_q[i] <= sb_d[i];
        end
    end

    // RAM output already sits one cycle after accept; add the remaining delay.
    if (READ_LAT > 1) begin : g_dly
        logic [31:0] dly_d [READ_LAT-1];
        logic [31:0] dly_q [READ_LAT-1];

        // Data delay line next-state.
        always_comb begin
            dly_d[0] = ram_rdata;
            for (int i = 1; i < READ_LAT - 1; i++) dly_d[i] = dly_q[i-1];
        end

        // Data delay registers.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < READ_LAT - 1; i++) dly_q[i] <= '0;
            end else begin
                for (int i = 0; i < READ_LAT - 1; i++) dly_q[i] <= dly_d[i];
            end
        end

        assign ld_data = dly_q[READ_LAT-2];
    end else begin : g_nodly
        assign ld_data = ram_rdata;
    end

    assign sb_out    = sb_q[READ_LAT-1];
    assign req_ready = ready_q;

    // Final stage: lane select and extension; data forced to zero unless a good load.
    always_comb begin
        rsp_valid = sb_out.vld;
        rsp_err   = sb_out.vld & sb_out.err;
        rsp_rdata = '0;
        if (sb_out.vld && !sb_out.we && !sb_out.err) begin
            rsp_rdata = ld_extend(ld_data, sb_out.off, sb_out.size, sb_out.uns);
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;

    // Saturating counters keyed on the accept edge.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept && !err && !req_we && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
        if (accept && !err && req_we && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
        if (accept && err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_lane_pipe.sv
// Bench for dmem_lane_pipe: three instances (READ_LAT 1..3, ADDR_W 4) fed identical traffic
// and compared against a byte-array model of memory. Honours DMEM_STATS_EN if defined.
module tb_dmem_lane_pipe;

    localparam int unsigned AW     = 4;
    localparam int unsigned NBYTES = 4 * (2 ** AW);

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  rdy, vld, err;
    logic [31:0] rdata [3];
`ifdef DMEM_STATS_EN
    logic [31:0] st_rd [3];
    logic [31:0] st_wr [3];
    logic [31:0] st_er [3];
`endif

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_lane_pipe #(
            .ADDR_W   (AW),
            .READ_LAT (g + 1),
            .INIT_FILE("")
        ) u_dut (
            .clock       (clock),
            .resetn      (resetn),
            .req_valid   (req_valid),
            .req_ready   (rdy[g]),
            .req_we      (req_we),
            .req_size    (req_size),
            .req_unsigned(req_unsigned),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (vld[g]),
            .rsp_rdata   (rdata[g]),
            .rsp_err     (err[g])
`ifdef DMEM_STATS_EN
            , .stat_rd_cnt (st_rd[g])
            , .stat_wr_cnt (st_wr[g])
            , .stat_err_cnt(st_er[g])
`endif
        );
    end

    typedef struct {
        int unsigned acc;   // posedge number at which the request is accepted
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic [7:0]  mem_m [NBYTES];
    exp_t        eq [$];
    int unsigned ptr [3];
    int unsigned cyc = 0;
    int unsigned n_rd = 0, n_wr = 0, n_er = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory as plain bytes, responses as a list of due times.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int unsigned n;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.acc  = cyc + 1;
        e.err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
                 (a >= NBYTES);
        e.data = '0;
        if (e.err) n_er++;
        else if (we) begin
            n_wr++;
            for (int i = 0; i < 4; i++) if (i < n) mem_m[a + i] = wd[8*i +: 8];
        end else begin
            n_rd++;
            v = '0;
            for (int i = 0; i < 4; i++) if (i < n) v[8*i +: 8] = mem_m[a + i];
            if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
            e.data = v;
        end
        eq.push_back(e);
    endtask

    // Compare each instance against its due response (or its absence) this cycle.
    task automatic check_rsp();
        for (int g = 0; g < 3; g++) begin
            if (ptr[g] < eq.size() && eq[ptr[g]].acc + g == cyc) begin
                chk($sformatf("rsp_valid[L%0d]", g + 1), 32'(vld[g]), 32'd1);
                chk($sformatf("rsp_rdata[L%0d]", g + 1), rdata[g], eq[ptr[g]].data);
                chk($sformatf("rsp_err[L%0d]", g + 1), 32'(err[g]), 32'(eq[ptr[g]].err));
                ptr[g]++;
            end else begin
                chk($sformatf("no_rsp[L%0d]", g + 1), 32'(vld[g]), 32'd0);
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        check_rsp();
        for (int g = 0; g < 3; g++) chk($sformatf("req_ready[L%0d]", g + 1), 32'(rdy[g]), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        model(we, sz, uns, a, wd);
    endtask

    task automatic idle();
        @(negedge clock);
        check_rsp();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_ready[L%0d]", tag, g + 1), 32'(rdy[g]), 32'd0);
            chk($sformatf("%s_valid[L%0d]", tag, g + 1), 32'(vld[g]), 32'd0);
            chk($sformatf("%s_rdata[L%0d]", tag, g + 1), rdata[g], 32'd0);
            chk($sformatf("%s_err[L%0d]", tag, g + 1), 32'(err[g]), 32'd0);
        end
    endtask

    // Assert reset mid-cycle, hold it, release on a falling edge.
    task automatic do_reset(input int unsigned hold);
        @(negedge clock);
        check_rsp();
        req_valid = 1'b0;
        #2 resetn = 1'b0;
        eq.delete();
        for (int g = 0; g < 3; g++) ptr[g] = 0;
        n_rd = 0;
        n_wr = 0;
        n_er = 0;
        #1 chk_reset_outputs("rst_async");
        repeat (hold) begin
            @(negedge clock);
            chk_reset_outputs("rst_hold");
        end
        resetn = 1'b1;
        #1 for (int g = 0; g < 3; g++) chk($sformatf("ready_release[L%0d]", g + 1), 32'(rdy[g]), 32'd0);
    endtask

    initial begin
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] a;

        for (int g = 0; g < 3; g++) ptr[g] = 0;
        for (int i = 0; i < int'(NBYTES); i++) mem_m[i] = '0;

        #1 resetn = 1'b0;
        #1 chk_reset_outputs("rst_init");
        repeat (3) begin
            @(negedge clock);
            chk_reset_outputs("rst_init_hold");
        end
        resetn = 1'b1;
        #1 for (int g = 0; g < 3; g++) chk($sformatf("ready_first[L%0d]", g + 1), 32'(rdy[g]), 32'd0);

        // Give every word a known value.
        for (int i = 0; i < int'(NBYTES / 4); i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
        idle();

        // Word store/load, then byte and half lane cases.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle();
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_8001);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF_FFFF);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h24, 32'h5555_5555);
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
        // Out of range must not alias onto word 0.
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D);
        issue(1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'h0000_00AA);
        issue(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
        repeat (4) idle();

        // Reset with loads in flight; earlier stores survive.
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h0BAD_CAFE);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        do_reset(3);
        idle();
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle();

        // Random mixed traffic, mostly back-to-back.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 8) begin
                we  = 1'($urandom);
                uns = 1'($urandom);
                sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 11) == 0) a = $urandom;
                else a = 32'($urandom_range(0, NBYTES + 15));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'b00;
                end
                issue(we, sz, uns, a, $urandom);
            end else begin
                idle();
            end
        end
        repeat (5) idle();

        for (int g = 0; g < 3; g++) begin
            chk($sformatf("drained[L%0d]", g + 1), 32'(ptr[g]), 32'(eq.size()));
        end
`ifdef DMEM_STATS_EN
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("stat_rd[L%0d]", g + 1), st_rd[g], 32'(n_rd));
            chk($sformatf("stat_wr[L%0d]", g + 1), st_wr[g], 32'(n_wr));
            chk($sformatf("stat_err[L%0d]", g + 1), st_er[g], 32'(n_er));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
